// File: rtl/inert_pkg.sv
// Shared types and helpers for the yaw-rate integrator.
// Includes the state encoding, the fast-calibration depth and the rate conditioning function.
package inert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } inert_state_t;

    localparam int FAST_CAL_LOG2 = 3;

    // Clamp to a symmetric dw-bit range, then zero anything inside the deadband.
    function automatic longint sat_db(
        input longint d,
        input int     dw,
        input longint db
    );
        longint lim;
        longint c;
        lim = (longint'(1) <<< (dw - 1)) - 1;
        if (d > lim)
            c = lim;
        else if (d < -lim)
            c = -lim;
        else
            c = d;
        if ((c < db) && (c > -db))
            c = 0;
        return c;
    endfunction

endpackage

// File: rtl/inert_integrator_gen_if.sv
// Sample/heading bus between the SPI front end and the yaw integrator.
// The master side drives samples and control; the slave side returns heading and status.
interface inert_integrator_gen_if #(
    parameter int DATA_W = 16,
    parameter int HEAD_W = 12
);
    logic                     vld;
    logic signed [DATA_W-1:0] yaw_rt;
    logic                     strt_cal;
    logic                     moving;
    logic                     lftIR;
    logic                     rghtIR;
    logic                     cal_done;
    logic                     calibrated;
    logic signed [HEAD_W-1:0] heading;
    logic                     rdy;

    modport master (
        output vld, yaw_rt, strt_cal, moving, lftIR, rghtIR,
        input  cal_done, calibrated, heading, rdy
    );

    modport slave (
        input  vld, yaw_rt, strt_cal, moving, lftIR, rghtIR,
        output cal_done, calibrated, heading, rdy
    );
endinterface

// File: rtl/inert_cal_avg.sv
// Gyro offset calibration: sums 2^LOG2N samples and keeps their arithmetic mean.
// done is a combinational strobe on the accepted final sample.
module inert_cal_avg
    import inert_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CAL_LOG2 = 11,
    parameter int FAST_SIM = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] offset,
    output logic                     done
);
    localparam int LOG2N = (FAST_SIM != 0) ? FAST_CAL_LOG2 : CAL_LOG2;
    localparam int SUM_W = DATA_W + CAL_LOG2;
    localparam logic [CAL_LOG2-1:0] ONES = '1;
    localparam logic [CAL_LOG2-1:0] LAST = ONES >> (CAL_LOG2 - LOG2N);
    localparam logic [CAL_LOG2-1:0] ONE  = {{(CAL_LOG2-1){1'b0}}, 1'b1};

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_nx;
    logic [CAL_LOG2-1:0]     cnt;

    assign sum_nx = sum + SUM_W'(sample);
    assign done   = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum    <= '0;
            cnt    <= '0;
            offset <= '0;
        end else if (clr) begin
            sum <= '0;
            cnt <= '0;
        end else if (en) begin
            if (done) begin
                sum    <= '0;
                cnt    <= '0;
                offset <= DATA_W'(sum_nx >>> LOG2N);
            end else begin
                sum <= sum_nx;
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/inert_integrator_gen.sv
// Yaw-rate integrator: offset calibration, deadband, wrapping heading accumulator.
// Define INERT_IR_FUSE_EN to add IR guard-rail drift nudging in RUN.
module inert_integrator_gen
    import inert_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int HEAD_W   = 12,
    parameter int FRAC_W   = 15,
    parameter int CAL_LOG2 = 11,
    parameter int FAST_SIM = 0,
    parameter int DEADBAND = 8,
    parameter int IR_NUDGE = 512
) (
    input logic                  clk,
    input logic                  rst,
    inert_integrator_gen_if.slave bus
);
    localparam int ACC_W = HEAD_W + FRAC_W;

    inert_state_t             state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  e_ext;
    logic signed [ACC_W-1:0]  nudge;
    logic signed [DATA_W-1:0] offset;
    logic                     cal_en;
    logic                     cal_fin;
    logic                     cal_done_q;
    logic                     calibrated_q;
    logic                     rdy_q;

    // A sample arriving with strt_cal is dropped, never counted.
    assign cal_en = (state == CAL) && bus.vld && !bus.strt_cal;

    inert_cal_avg #(
        .DATA_W  (DATA_W),
        .CAL_LOG2(CAL_LOG2),
        .FAST_SIM(FAST_SIM)
    ) u_cal (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.strt_cal),
        .en    (cal_en),
        .sample(bus.yaw_rt),
        .offset(offset),
        .done  (cal_fin)
    );

    always_comb begin
        e_ext = ACC_W'(sat_db(longint'(bus.yaw_rt) - longint'(offset),
                              DATA_W, longint'(DEADBAND)));
    end

`ifdef INERT_IR_FUSE_EN
    always_comb begin
        nudge = '0;
        unique case (1'b1)
            (bus.rghtIR && !bus.lftIR): nudge = ACC_W'(IR_NUDGE);
            (bus.lftIR && !bus.rghtIR): nudge = -ACC_W'(IR_NUDGE);
            default:                    nudge = '0;
        endcase
    end
`else
    logic unused_ir;
    assign unused_ir = bus.lftIR ^ bus.rghtIR ^ (IR_NUDGE != 0);
    assign nudge     = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cal_done_q   <= 1'b0;
            calibrated_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            cal_done_q <= 1'b0;
            rdy_q      <= 1'b0;
            if (bus.strt_cal) begin
                state        <= CAL;
                calibrated_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    CAL: begin
                        if (cal_fin) begin
                            state        <= RUN;
                            acc          <= '0;
                            cal_done_q   <= 1'b1;
                            calibrated_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.vld) begin
                            rdy_q <= 1'b1;
                            if (bus.moving)
                                acc <= acc + e_ext + nudge;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.heading    = acc[ACC_W-1:FRAC_W];
    assign bus.cal_done   = cal_done_q;
    assign bus.calibrated = calibrated_q;
    assign bus.rdy        = rdy_q;

endmodule

// File: tb/tb_inert_integrator_gen.sv
// Scoreboard bench for inert_integrator_gen (FAST_SIM=1).
// Stimulus pushes expected events; a negedge monitor pops and compares them.
module tb_inert_integrator_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inert_integrator_gen_if #(.DATA_W(16), .HEAD_W(12)) bus ();

    inert_integrator_gen #(
        .DATA_W  (16),
        .HEAD_W  (12),
        .FRAC_W  (15),
        .CAL_LOG2(11),
        .FAST_SIM(1),
        .DEADBAND(8),
        .IR_NUDGE(512)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit         is_cal;
        logic [11:0] head;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [11:0] hd(input longint a);
        return a[26:15];
    endfunction

    always @(negedge clk) begin
        if (bus.cal_done || bus.rdy) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_evt: cal_done=%0b rdy=%0b heading=%0h want none",
                         bus.cal_done, bus.rdy, bus.heading);
            end else begin
                mon_e = q.pop_front();
                chk("evt_kind", {30'b0, bus.cal_done, bus.rdy},
                    mon_e.is_cal ? 32'd2 : 32'd1);
                chk("evt_head", {20'b0, bus.heading}, {20'b0, mon_e.head});
                if (mon_e.is_cal)
                    chk("cal_level", {31'b0, bus.calibrated}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int yaw, input bit mv);
        bus.yaw_rt = 16'(yaw);
        bus.moving = mv;
        bus.vld    = 1'b1;
        tick();
        bus.vld    = 1'b0;
    endtask

    task automatic run(input int yaw, input bit mv, input logic [11:0] h);
        q.push_back('{1'b0, h});
        send(yaw, mv);
    endtask

    task automatic pulse_strt();
        bus.strt_cal = 1'b1;
        tick();
        bus.strt_cal = 1'b0;
    endtask

    task automatic feed_cal(input int yaw, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)
                q.push_back('{1'b1, 12'h000});
            send(yaw, 1'b0);
        end
    endtask

    initial begin
        bus.vld      = 1'b0;
        bus.yaw_rt   = '0;
        bus.strt_cal = 1'b0;
        bus.moving   = 1'b0;
        bus.lftIR    = 1'b0;
        bus.rghtIR   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_head", {20'b0, bus.heading}, 32'h0);
        chk("rst_cal_done", {31'b0, bus.cal_done}, 32'h0);
        chk("rst_calibrated", {31'b0, bus.calibrated}, 32'h0);
        chk("rst_rdy", {31'b0, bus.rdy}, 32'h0);

        send(10, 1'b1);

        // Offset 100: matching rate integrates to nothing.
        pulse_strt();
        @(negedge clk);
        chk("cal_level_low", {31'b0, bus.calibrated}, 32'h0);
        feed_cal(100, 8);
        repeat (5) run(100, 1'b1, 12'h000);

        // Build acc to 32760, then probe the deadband edges.
        for (int k = 1; k <= 32; k++) run(1100, 1'b1, 12'h000);
        run(860, 1'b1, 12'h000);
        run(107, 1'b1, 12'h000);
        run(108, 1'b1, 12'h001);
        run(93, 1'b1, 12'h001);
        run(92, 1'b1, 12'h000);

        repeat (3) run(20000, 1'b0, 12'h000);
        run(108, 1'b1, 12'h001);

        // Recalibrate to offset -100 and saturate.
        pulse_strt();
        @(negedge clk);
        chk("hold_head", {20'b0, bus.heading}, 32'h1);
        chk("recal_level", {31'b0, bus.calibrated}, 32'h0);
        feed_cal(-100, 8);
        run(32767, 1'b1, 12'h000);
        run(32767, 1'b1, 12'h001);

        // Offset 0: long integration then wrap past 0x7FF.
        pulse_strt();
        @(negedge clk);
        chk("hold_head2", {20'b0, bus.heading}, 32'h1);
        feed_cal(0, 8);
        for (int k = 1; k <= 32768; k++)
            run(1000, 1'b1, hd(longint'(k) * 1000));
        @(negedge clk);
        chk("long_head", {20'b0, bus.heading}, 32'h3E8);
        for (int j = 1; j <= 1049; j++)
            run(32767, 1'b1, hd(64'sd32768000 + longint'(j) * 32767));
        @(negedge clk);
        chk("wrap_head", {20'b0, bus.heading}, 32'h800);

        // strt_cal with vld: sample dropped.
        bus.strt_cal = 1'b1;
        bus.yaw_rt   = 16'(5000);
        bus.vld      = 1'b1;
        tick();
        bus.strt_cal = 1'b0;
        bus.vld      = 1'b0;
        @(negedge clk);
        chk("drop_level", {31'b0, bus.calibrated}, 32'h0);
        chk("drop_head", {20'b0, bus.heading}, 32'h800);
        feed_cal(800, 8);
        run(800, 1'b1, 12'h000);
        run(32767, 1'b1, 12'h000);
        run(32767, 1'b1, 12'h001);

        // Reset in the middle of calibration.
        pulse_strt();
        repeat (3) send(50, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rcal_head", {20'b0, bus.heading}, 32'h0);
        chk("rcal_calibrated", {31'b0, bus.calibrated}, 32'h0);
        chk("rcal_cal_done", {31'b0, bus.cal_done}, 32'h0);
        chk("rcal_rdy", {31'b0, bus.rdy}, 32'h0);
        send(10, 1'b1);

        pulse_strt();
        feed_cal(0, 8);
`ifdef INERT_IR_FUSE_EN
        bus.rghtIR = 1'b1;
        for (int k = 1; k <= 64; k++)
            run(0, 1'b1, hd(longint'(k) * 512));
        bus.lftIR = 1'b1;
        repeat (10) run(0, 1'b1, 12'h001);
        bus.rghtIR = 1'b0;
        for (int k = 1; k <= 64; k++)
            run(0, 1'b1, hd(64'sd32768 - longint'(k) * 512));
        bus.lftIR = 1'b0;
`else
        bus.rghtIR = 1'b1;
        repeat (10) run(0, 1'b1, 12'h000);
        bus.rghtIR = 1'b0;
        bus.lftIR  = 1'b1;
        repeat (10) run(0, 1'b1, 12'h000);
        bus.lftIR  = 1'b0;
`endif

        repeat (3) tick();
        chk("queue_drain", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
